// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the decode/write-back stage:
// instruction codes, register IDs, status codes and the E-register bubble value.
package y86_pkg;

    localparam int NREG = 15;
    localparam int XLEN = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    typedef struct packed {
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [3:0]      stat;
        logic [XLEN-1:0] valC;
        logic [XLEN-1:0] valA;
        logic [XLEN-1:0] valB;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
        logic [3:0]      srcA;
        logic [3:0]      srcB;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        icode: INOP,  ifun: 4'h0,  stat: SAOK,
        valC:  '0,    valA: '0,    valB: '0,
        dstE:  RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
    };

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports
// (E and M) applied at posedge. When both ports target the same register the
// M port wins. ID 4'hF (RNONE) reads as zero and is never written.
module y86_regfile
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    input  logic [3:0]      dstE,
    input  logic [XLEN-1:0] valE,
    input  logic [3:0]      dstM,
    input  logic [XLEN-1:0] valM
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Next register contents: E write first so a same-register M write overrides it.
    always_comb begin
        regs_d = regs_q;
        if (dstE != RNONE) regs_d[dstE] = valE;
        if (dstM != RNONE) regs_d[dstM] = valM;
    end

    // Register array with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write array; same-cycle writes are covered by forwarding.
    assign valA = (srcA == RNONE) ? '0 : regs_q[srcA];
    assign valB = (srcB == RNONE) ? '0 : regs_q[srcB];

endmodule

// File: rtl/decode_wb_stage.sv
// Y86-64 decode/write-back stage: decodes register IDs from the D register,
// reads the register file, selects operands (optionally forwarded), and loads
// the E pipeline register. W-stage results are written into the register file.
// Build option: DECODE_FWD_EN enables e/M/W operand forwarding; without it the
// operands come only from the register file and hazard control must stall.
module decode_wb_stage
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [3:0]      D_rA,
    input  logic [3:0]      D_rB,
    input  logic [3:0]      D_stat,
    input  logic [63:0]     D_valC,
    input  logic [63:0]     D_valP,
    input  logic            E_bubble,
    input  logic [3:0]      e_dstE,
    input  logic [63:0]     e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [3:0]      M_dstM,
    input  logic [63:0]     M_valE,
    input  logic [63:0]     m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [3:0]      W_dstM,
    input  logic [63:0]     W_valE,
    input  logic [63:0]     W_valM,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [3:0]      E_stat,
    output logic [63:0]     E_valC,
    output logic [63:0]     E_valA,
    output logic [63:0]     E_valB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB
);

    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [XLEN-1:0] rf_valA;
    logic [XLEN-1:0] rf_valB;
    logic [XLEN-1:0] fwd_valA;
    logic [XLEN-1:0] fwd_valB;
    e_reg_t          e_d;
    e_reg_t          e_q;

    y86_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .srcA  (d_srcA),
        .srcB  (d_srcB),
        .valA  (rf_valA),
        .valB  (rf_valB),
        .dstE  (W_dstE),
        .valE  (W_valE),
        .dstM  (W_dstM),
        .valM  (W_valM)
    );

    // Register-ID decode; unknown icodes fall through to RNONE everywhere.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            IRRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
            IIRMOVQ: begin d_dstE = D_rB; end
            IRMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
            IMRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
            IOPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
            ICALL:   begin d_srcB = RSP; d_dstE = RSP; end
            IRET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
            IPUSHQ:  begin d_srcA = D_rA; d_srcB = RSP; d_dstE = RSP; end
            IPOPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA; end
            default: ;
        endcase
    end

`ifdef DECODE_FWD_EN
    // Youngest producer wins; RNONE never matches so it reads as zero.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [3:0] src, input logic [XLEN-1:0] rf);
        if (src == RNONE)        return '0;
        else if (src == e_dstE)  return e_valE;
        else if (src == M_dstM)  return m_valM;
        else if (src == M_dstE)  return M_valE;
        else if (src == W_dstM)  return W_valM;
        else if (src == W_dstE)  return W_valE;
        else                     return rf;
    endfunction

    // Operand forwarding for both source ports.
    always_comb begin
        fwd_valA = fwd_sel(d_srcA, rf_valA);
        fwd_valB = fwd_sel(d_srcB, rf_valB);
    end
`else
    // Without forwarding the execute/memory results are not looked at here.
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM};

    // Operands come straight from the register file.
    always_comb begin
        fwd_valA = rf_valA;
        fwd_valB = rf_valB;
    end
`endif

    // Next E-register contents: bubble or decoded fields; call/jXX carry valP in valA.
    always_comb begin
        e_d = E_BUBBLE;
        if (!E_bubble) begin
            e_d.icode = D_icode;
            e_d.ifun  = D_ifun;
            e_d.stat  = D_stat;
            e_d.valC  = D_valC;
            e_d.valA  = (D_icode == ICALL || D_icode == IJXX) ? D_valP : fwd_valA;
            e_d.valB  = fwd_valB;
            e_d.dstE  = d_dstE;
            e_d.dstM  = d_dstM;
            e_d.srcA  = d_srcA;
            e_d.srcB  = d_srcB;
        end
    end

    // E pipeline register with asynchronous return to the bubble value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) e_q <= E_BUBBLE;
        else       e_q <= e_d;
    end

    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_stat  = e_q.stat;
    assign E_valC  = e_q.valC;
    assign E_valA  = e_q.valA;
    assign E_valB  = e_q.valB;
    assign E_dstE  = e_q.dstE;
    assign E_dstM  = e_q.dstM;
    assign E_srcA  = e_q.srcA;
    assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_wb_stage.sv
// Self-checking bench for decode_wb_stage: directed scenarios with literal
// expectations plus randomized decode/write-back traffic against a table-driven
// model. Honours DECODE_FWD_EN the same way the design does.
module tb_decode_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_icode, E_ifun, E_stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    decode_wb_stage dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
        .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural register state as the model sees it.
    logic [63:0] m_regs [15];

    // Expected E register after the next edge.
    logic [3:0]  x_icode, x_ifun, x_stat, x_dstE, x_dstM, x_srcA, x_srcB;
    logic [63:0] x_valC, x_valA, x_valB;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB})             return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6})       return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    // Operand value for a source ID: producer list scanned youngest-first, else register.
    function automatic logic [63:0] m_operand(input logic [3:0] src);
        logic [3:0]  pd [5];
        logic [63:0] pv [5];
        if (src == 4'hF) return 64'h0;
`ifdef DECODE_FWD_EN
        pd[0] = e_dstE; pv[0] = e_valE;
        pd[1] = M_dstM; pv[1] = m_valM;
        pd[2] = M_dstE; pv[2] = M_valE;
        pd[3] = W_dstM; pv[3] = W_valM;
        pd[4] = W_dstE; pv[4] = W_valE;
        for (int k = 0; k < 5; k++) if (pd[k] == src) return pv[k];
`else
        pd[0] = 4'hF; pv[0] = 64'h0;
        if (pd[0] == src) return pv[0];
`endif
        return m_regs[src];
    endfunction

    task automatic predict();
        if (E_bubble) begin
            x_icode = 4'h1; x_ifun = 4'h0; x_stat = 4'h1;
            x_valC = 64'h0; x_valA = 64'h0; x_valB = 64'h0;
            x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
        end else begin
            x_icode = D_icode; x_ifun = D_ifun; x_stat = D_stat; x_valC = D_valC;
            x_srcA = m_srcA(D_icode, D_rA);
            x_srcB = m_srcB(D_icode, D_rB);
            x_dstE = m_dstE(D_icode, D_rB);
            x_dstM = m_dstM(D_icode, D_rA);
            x_valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_operand(x_srcA);
            x_valB = m_operand(x_srcB);
        end
    endtask

    task automatic model_writeback();
        if (W_dstE != 4'hF) m_regs[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_regs[W_dstM] = W_valM;
    endtask

    task automatic check_e(input string tag);
        chk({tag, ".E_icode"}, E_icode, x_icode);
        chk({tag, ".E_ifun"},  E_ifun,  x_ifun);
        chk({tag, ".E_stat"},  E_stat,  x_stat);
        chk({tag, ".E_valC"},  E_valC,  x_valC);
        chk({tag, ".E_valA"},  E_valA,  x_valA);
        chk({tag, ".E_valB"},  E_valB,  x_valB);
        chk({tag, ".E_dstE"},  E_dstE,  x_dstE);
        chk({tag, ".E_dstM"},  E_dstM,  x_dstM);
        chk({tag, ".E_srcA"},  E_srcA,  x_srcA);
        chk({tag, ".E_srcB"},  E_srcB,  x_srcB);
    endtask

    // Inputs are already driven (after negedge): check comb srcs, clock once, check E.
    task automatic cycle(input string tag);
        #1;
        if (!E_bubble) begin
            chk({tag, ".d_srcA"}, d_srcA, m_srcA(D_icode, D_rA));
            chk({tag, ".d_srcB"}, d_srcB, m_srcB(D_icode, D_rB));
        end
        predict();
        @(posedge clk);
        model_writeback();
        #1;
        check_e(tag);
        @(negedge clk);
    endtask

    task automatic quiet();
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF; D_stat = 4'h1;
        D_valC = 64'h0; D_valP = 64'h0; E_bubble = 1'b0;
        e_dstE = 4'hF; e_valE = 64'h0;
        M_dstE = 4'hF; M_dstM = 4'hF; M_valE = 64'h0; m_valM = 64'h0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_valE = 64'h0; W_valM = 64'h0;
    endtask

    function automatic logic [3:0] rand_dst();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    endfunction

    task automatic randomize_inputs();
        D_icode = 4'($urandom_range(0, 15));
        D_ifun  = 4'($urandom_range(0, 15));
        D_rA    = 4'($urandom_range(0, 15));
        D_rB    = 4'($urandom_range(0, 15));
        D_stat  = 4'($urandom_range(1, 4));
        D_valC  = {$urandom, $urandom};
        D_valP  = {$urandom, $urandom};
        E_bubble = ($urandom_range(0, 7) == 0);
        e_dstE = rand_dst(); e_valE = {$urandom, $urandom};
        M_dstE = rand_dst(); M_dstM = rand_dst();
        M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
        W_dstE = rand_dst(); W_dstM = rand_dst();
        W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
    endtask

    task automatic mid_reset();
        randomize_inputs();
        #2 reset = 1'b1;
        #1;
        chk("rst.E_icode", E_icode, 64'h1);
        chk("rst.E_stat",  E_stat,  64'h1);
        chk("rst.E_dstE",  E_dstE,  64'hF);
        chk("rst.E_dstM",  E_dstM,  64'hF);
        chk("rst.E_srcA",  E_srcA,  64'hF);
        chk("rst.E_valA",  E_valA,  64'h0);
        for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
        @(negedge clk);
        reset = 1'b0;
        quiet();
        // Every register must read back zero through the operand path.
        for (int r = 0; r < 15; r++) begin
            D_icode = 4'h6; D_rA = 4'(r); D_rB = 4'(14 - r);
            cycle("rst_read");
            chk("rst_read.valA", E_valA, 64'h0);
            chk("rst_read.valB", E_valB, 64'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
        #1;
        chk("init.E_icode", E_icode, 64'h1);
        chk("init.E_dstE",  E_dstE,  64'hF);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Regfile path: write r3, read it next cycle with no forwarding sources.
        quiet(); W_dstE = 4'h3; W_valE = 64'h55;
        cycle("wb_r3");
        quiet(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h1;
        cycle("read_r3");
        chk("t2.E_valA", E_valA, 64'h55);

        // Forwarding priority: r2 holds 0x77 in the file, e and M both target r2.
        quiet(); W_dstE = 4'h2; W_valE = 64'h77;
        cycle("wb_r2");
        quiet(); e_dstE = 4'h2; e_valE = 64'h10; M_dstE = 4'h2; M_valE = 64'h20;
        D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h2;
        cycle("fwd_prio");
`ifdef DECODE_FWD_EN
        chk("t3.E_valA", E_valA, 64'h10);
`else
        chk("t3.E_valA", E_valA, 64'h77);
`endif

        // popq %rsp: both W ports hit r4, the memory value must land.
        quiet(); W_dstE = 4'h4; W_valE = 64'h108; W_dstM = 4'h4; W_valM = 64'hAA;
        cycle("popq_wb");
        quiet(); D_icode = 4'h6; D_rA = 4'h4; D_rB = 4'h3;
        cycle("read_r4");
        chk("t4.E_valA", E_valA, 64'hAA);
        chk("t4.E_valB", E_valB, 64'h55);

        // call: valA takes valP, rsp is source B and dest E.
        quiet(); D_icode = 4'h8; D_valP = 64'h40; D_valC = 64'h1234;
        cycle("call");
        chk("t5.E_valA", E_valA, 64'h40);
        chk("t5.E_srcB", E_srcB, 64'h4);
        chk("t5.E_dstE", E_dstE, 64'h4);
        chk("t5.E_dstM", E_dstM, 64'hF);
        chk("t5.E_valB", E_valB, 64'hAA);

        // Bubble over irmovq, then load it.
        quiet(); D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h7; D_valC = 64'hDEAD_BEEF; E_bubble = 1'b1;
        cycle("bubble");
        chk("t6.E_icode", E_icode, 64'h1);
        chk("t6.E_dstE",  E_dstE,  64'hF);
        E_bubble = 1'b0;
        cycle("irmovq");
        chk("t6.E_icode2", E_icode, 64'h3);
        chk("t6.E_valC",   E_valC,  64'hDEAD_BEEF);
        chk("t6.E_dstE2",  E_dstE,  64'h7);

        // Unknown icode: all register fields come out as RNONE, status passes through.
        quiet(); D_icode = 4'hD; D_rA = 4'h1; D_rB = 4'h2; D_stat = 4'h4;
        cycle("bad_icode");
        chk("t7.E_stat", E_stat, 64'h4);
        chk("t7.E_srcA", E_srcA, 64'hF);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) mid_reset();
            randomize_inputs();
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1);
    end

endmodule
